gpr_file_sb: RTL and testbench

Parametrised successor to the single-cycle register file, for the pipelined core. It has a configurable-width and configurable-depth general-purpose register array, two combinational read ports and one writeback port. A per-register busy scoreboard is set at issue and cleared at writeback, and it drives an issue stall. The block sits between the decode/issue stage and the writeback stage.

---
 rtl/gpr_pkg.sv | 9 +
 rtl/gpr_scoreboard.sv | 45 ++++
 rtl/gpr_file_sb.sv | 76 +++++++
 tb/tb_gpr_file_sb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared defaults and types for the pipelined GPR file and its busy scoreboard.
package gpr_pkg;
    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0]          xlen_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback (set wins); yields RAW/WAW hazard terms.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_fire,
    input  logic [AW-1:0]    iss_rd_id,
    input  logic             iss_use_rs1,
    input  logic             iss_use_rs2,
    input  logic [AW-1:0]    rs1_id,
    input  logic [AW-1:0]    rs2_id,
    input  logic             clr1,
    input  logic             clr2,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_id,
    output logic             raw1,
    output logic             raw2,
    output logic             waw,
    output logic [NREGS-1:0] busy_vec
);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [NREGS-1:0] set_mask, clr_mask;

    // Masks never touch x0, so busy[0] stays clear without special casing.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_fire && iss_rd_id != ZERO) set_mask[iss_rd_id] = 1'b1;
        if (wb_en && wb_id != ZERO)        clr_mask[wb_id]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_vec <= '0;
        else        busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end

    assign raw1 = iss_use_rs1 & busy_vec[rs1_id] & ~clr1;
    assign raw2 = iss_use_rs2 & busy_vec[rs2_id] & ~clr2;
    assign waw  = busy_vec[iss_rd_id] & (iss_rd_id != ZERO) & ~(wb_en & (wb_id == iss_rd_id));
endmodule

// File: rtl/gpr_file_sb.sv
// GPR array with two combinational read ports, one writeback port and a busy scoreboard driving issue stall.
// GPR_BYPASS_EN: forward same-cycle writeback to the read ports and let dependents issue in that cycle.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs1_id,
    input  logic [AW-1:0]    rs2_id,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd_id,
    input  logic             iss_use_rs1,
    input  logic             iss_use_rs2,
    output logic             iss_stall,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_id,
    input  logic [XLEN-1:0]  wb_data,
    output logic [NREGS-1:0] busy_vec
);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic                       wb_act;
    logic                       clr1, clr2;
    logic                       raw1, raw2, waw;

    assign wb_act = wb_en & (wb_id != ZERO);

    // regs[0] is never written, so it reads back as zero from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      regs <= '0;
        else if (wb_act) regs[wb_id] <= wb_data;
    end

`ifdef GPR_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = wb_act & (wb_id == rs1_id);
    assign hit2 = wb_act & (wb_id == rs2_id);
    assign clr1 = hit1;
    assign clr2 = hit2;
    assign rs1_data = hit1 ? wb_data : regs[rs1_id];
    assign rs2_data = hit2 ? wb_data : regs[rs2_id];
`else
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
    assign rs1_data = regs[rs1_id];
    assign rs2_data = regs[rs2_id];
`endif

    assign iss_stall = iss_valid & (raw1 | raw2 | waw);

    gpr_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_fire   (iss_valid & ~iss_stall),
        .iss_rd_id  (iss_rd_id),
        .iss_use_rs1(iss_use_rs1),
        .iss_use_rs2(iss_use_rs2),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .clr1       (clr1),
        .clr2       (clr2),
        .wb_en      (wb_en),
        .wb_id      (wb_id),
        .raw1       (raw1),
        .raw2       (raw2),
        .waw        (waw),
        .busy_vec   (busy_vec)
    );
endmodule

// File: tb/tb_gpr_file_sb.sv
// Scoreboard bench for gpr_file_sb: directed scenarios plus random traffic against an array/bitmask model.
module tb_gpr_file_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    rs1_id, rs2_id, iss_rd_id, wb_id;
    logic [XLEN-1:0]  rs1_data, rs2_data, wb_data;
    logic             iss_valid, iss_use_rs1, iss_use_rs2, iss_stall, wb_en;
    logic [NREGS-1:0] busy_vec;

    gpr_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .iss_valid(iss_valid), .iss_rd_id(iss_rd_id), .iss_use_rs1(iss_use_rs1),
        .iss_use_rs2(iss_use_rs2), .iss_stall(iss_stall),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  d1, d2;
        logic             stall;
        logic [NREGS-1:0] busy;
    } exp_t;

    exp_t             expq[$];
    logic [XLEN-1:0]  mregs [NREGS];
    logic [NREGS-1:0] mbusy;
    int               total = 0;
    int               bad   = 0;
    bit               done  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    // Spec-level model: expected outputs for this cycle, then the state after the next edge.
    task automatic drive(input bit v, input int rd, input bit u1, input bit u2,
                         input int r1, input int r2, input bit we, input int wid,
                         input logic [XLEN-1:0] wd);
        exp_t e;
        bit   h1, h2, st;
        @(negedge clk);
        iss_valid = v; iss_rd_id = AW'(rd); iss_use_rs1 = u1; iss_use_rs2 = u2;
        rs1_id = AW'(r1); rs2_id = AW'(r2); wb_en = we; wb_id = AW'(wid); wb_data = wd;
        h1 = BYP && we && wid != 0 && wid == r1;
        h2 = BYP && we && wid != 0 && wid == r2;
        e.d1 = (r1 == 0) ? '0 : (h1 ? wd : mregs[r1]);
        e.d2 = (r2 == 0) ? '0 : (h2 ? wd : mregs[r2]);
        st = v && ((u1 && r1 != 0 && mbusy[r1] && !h1) ||
                   (u2 && r2 != 0 && mbusy[r2] && !h2) ||
                   (rd != 0 && mbusy[rd] && !(we && wid == rd)));
        e.stall = st;
        e.busy  = mbusy;
        expq.push_back(e);
        if (we && wid != 0) begin mregs[wid] = wd; mbusy[wid] = 1'b0; end
        if (v && !st && rd != 0) mbusy[rd] = 1'b1;
    endtask

    task automatic idle(input int r1, input int r2);
        drive(0, 0, 0, 0, r1, r2, 0, 0, '0);
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a response.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rs1_data", 256'(rs1_data), 256'(e.d1));
                chk("rs2_data", 256'(rs2_data), 256'(e.d2));
                chk("iss_stall", 256'(iss_stall), 256'(e.stall));
                chk("busy_vec", 256'(busy_vec), 256'(e.busy));
            end
        end
    end

    initial begin
        logic [XLEN-1:0] ones;
        logic [63:0]     k1234, kbeef;
        int              rd, r1, r2, wid, pick;
        ones  = '1;
        k1234 = 64'h1234;
        kbeef = 64'hDEAD_BEEF;
        rst_n = 1'b0;
        iss_valid = 0; iss_rd_id = '0; iss_use_rs1 = 0; iss_use_rs2 = 0;
        rs1_id = '0; rs2_id = '0; wb_en = 0; wb_id = '0; wb_data = '0;
        model_reset();
        #12;
        chk("reset_busy", 256'(busy_vec), 256'(0));
        chk("reset_stall", 256'(iss_stall), 256'(0));
        chk("reset_rs1", 256'(rs1_data), 256'(0));
        @(negedge clk) rst_n = 1'b1;

        // 1: all indices read zero, then async reset of live reservations
        for (int i = 0; i < NREGS; i++) idle(i, NREGS - 1 - i);
        drive(1, 2, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 8, 0, 0, 0, 0, 0, 0, '0);
        @(posedge clk);
        #3;
        chk("busy_pre_rst", 256'(busy_vec), 256'(mbusy));
        chk("busy_0x104", 256'(busy_vec), 256'(NREGS'(32'h104)));
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 256'(busy_vec), 256'(0));
        iss_valid = 0; wb_en = 0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // 2: x0 is hardwired
        drive(0, 0, 0, 0, 0, 0, 1, 0, XLEN'(kbeef));
        idle(0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, '0);
        idle(0, 0);

        // 3: RAW on x5 resolved by writeback
        drive(1, 5, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 6, 1, 0, 5, 0, 0, 0, '0);
        drive(1, 6, 1, 0, 5, 0, 1, 5, XLEN'(k1234));
        drive(1, 6, 1, 0, 5, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 5, 6, 1, 6, XLEN'(64'h66));

        // 4: WAW on x7, then issue together with writeback (set wins)
        drive(1, 7, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 7, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 7, 0, 0, 0, 0, 1, 7, XLEN'(64'h7777));
        idle(7, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 7, XLEN'(64'h7070));

        // 5: full-width write to a non-busy register
        drive(0, 0, 0, 0, 0, 9, 1, 9, ones);
        idle(0, 9);

        // random traffic; writebacks favour busy registers
        for (int n = 0; n < 600; n++) begin
            rd = $urandom_range(0, NREGS - 1);
            r1 = $urandom_range(0, NREGS - 1);
            r2 = $urandom_range(0, NREGS - 1);
            wid = $urandom_range(0, NREGS - 1);
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, NREGS - 1);
                for (int j = 0; j < NREGS; j++)
                    if (mbusy[(pick + j) % NREGS]) begin wid = (pick + j) % NREGS; break; end
            end
            drive($urandom_range(0, 3) != 0, rd, $urandom_range(0, 1), $urandom_range(0, 1),
                  r1, r2, $urandom_range(0, 2) != 0, wid, XLEN'({$urandom, $urandom}));
        end
        idle(0, 0);

        for (int c = 0; c < 10 && expq.size() > 0; c++) @(negedge clk);
        #4;
        if (expq.size() > 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d exp=0", expq.size());
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
